// File: rtl/xilinx_exit_status_monitor.sv
`default_nettype none
// ============================================================================
// Module   : xilinx_exit_status_monitor
// Purpose  : Watches the x_heep_system exit handshake on the FPGA board. It
//            captures the first exit event only, and latches the exit code and
//            a pass/fail verdict. It drives one status LED:
//              running -> heartbeat square wave (half-period HEARTBEAT_CYCLES)
//              pass    -> solid on
//              fail    -> blink pattern (see EXIT_BLINK_CODE_EN below)
// Build    : EXIT_BLINK_CODE_EN
//              defined   -> a fail blinks N pulses, then a GAP_CYCLES pause,
//                           repeated forever. N is the exit code low nibble,
//                           and a nibble of 0 counts as 16.
//              undefined -> a fail gives a plain square wave with half-period
//                           BLINK_CYCLES.
// Ports    : clk_i          system clock (x_heep_system domain)
//            rst_ni         asynchronous active-low reset
//            exit_valid_i   program-exit strobe/level
//            exit_value_i   [31:0] exit code, qualified by exit_valid_i
//            exit_done_o    sticky, program has exited
//            exit_pass_o    sticky, exit code was zero
//            exit_fail_o    sticky, exit code was non-zero
//            exit_code_o    [31:0] latched exit code
//            status_led_o   LED drive, active high
// Revision : 1.0 - initial release
// ============================================================================
module xilinx_exit_status_monitor #(
  parameter int unsigned HEARTBEAT_CYCLES = 25000000,
  parameter int unsigned BLINK_CYCLES     = 5000000,
  parameter int unsigned GAP_CYCLES       = 20000000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  output logic        exit_done_o,
  output logic        exit_pass_o,
  output logic        exit_fail_o,
  output logic [31:0] exit_code_o,
  output logic        status_led_o
);

  // The phase counter is shared by every state, so it is sized for the
  // longest period. The extra bit leaves headroom, so the counter cannot
  // overflow even when a parameter is an exact power of two.
  localparam int unsigned MAX_HB_BL  = (HEARTBEAT_CYCLES > BLINK_CYCLES) ?
                                       HEARTBEAT_CYCLES : BLINK_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_HB_BL > GAP_CYCLES) ? MAX_HB_BL : GAP_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

  localparam logic [CNT_W-1:0] HB_LAST    = CNT_W'(HEARTBEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

`ifdef EXIT_BLINK_CODE_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  // Fail sub-states: the LED is on in BLINK_ON, and off in BLINK_OFF and GAP.
  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_PASS      = 3'd1,
    ST_BLINK_ON  = 3'd2,
    ST_BLINK_OFF = 3'd3,
    ST_GAP       = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              led_q, led_d;
  logic              valid_q;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic [31:0]       code_q, code_d;
  logic              exit_event;

`ifdef EXIT_BLINK_CODE_EN
  logic [4:0]        pulse_q, pulse_d;   // number of the pulse in progress (1..16)
  logic [4:0]        blink_n;            // pulses per repetition

  // A non-zero code with a zero low nibble would otherwise give no pulses,
  // so it is shown as 16 pulses.
  assign blink_n = (code_q[3:0] == 4'd0) ? 5'd16 : {1'b0, code_q[3:0]};
`endif

  // Rising-edge detect. valid_q resets to 0, so a level that is already high
  // when reset is released still counts as one event.
  assign exit_event = exit_valid_i & ~valid_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    code_d  = code_q;
`ifdef EXIT_BLINK_CODE_EN
    pulse_d = pulse_q;
`endif

    case (state_q)
      ST_RUN: begin
        if (exit_event) begin
          // Capture is allowed only here, so every later event is ignored.
          done_d = 1'b1;
          pass_d = (exit_value_i == 32'd0);
          fail_d = (exit_value_i != 32'd0);
          code_d = exit_value_i;
          cnt_d  = '0;
          if (exit_value_i == 32'd0) begin
            state_d = ST_PASS;
            led_d   = 1'b1;
          end else begin
`ifdef EXIT_BLINK_CODE_EN
            state_d = ST_BLINK_ON;
            led_d   = 1'b1;
            pulse_d = 5'd1;
`else
            state_d = ST_FAIL;
            led_d   = 1'b0;
`endif
          end
        end else if (cnt_q == HB_LAST) begin
          cnt_d = '0;
          led_d = ~led_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_PASS: begin
        led_d = 1'b1;
      end

`ifdef EXIT_BLINK_CODE_EN
      ST_BLINK_ON: begin
        if (cnt_q == BLINK_LAST) begin
          state_d = ST_BLINK_OFF;
          cnt_d   = '0;
          led_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_BLINK_OFF: begin
        if (cnt_q == BLINK_LAST) begin
          cnt_d = '0;
          if (pulse_q == blink_n) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_BLINK_ON;
            led_d   = 1'b1;
            pulse_d = pulse_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_BLINK_ON;
          cnt_d   = '0;
          led_d   = 1'b1;
          pulse_d = 5'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`else
      ST_FAIL: begin
        if (cnt_q == BLINK_LAST) begin
          cnt_d = '0;
          led_d = ~led_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      led_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= 32'd0;
`ifdef EXIT_BLINK_CODE_EN
      pulse_q <= 5'd0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      valid_q <= exit_valid_i;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      code_q  <= code_d;
`ifdef EXIT_BLINK_CODE_EN
      pulse_q <= pulse_d;
`endif
    end
  end

  assign exit_done_o  = done_q;
  assign exit_pass_o  = pass_q;
  assign exit_fail_o  = fail_q;
  assign exit_code_o  = code_q;
  assign status_led_o = led_q;

endmodule
`default_nettype wire

// File: tb/tb_xilinx_exit_status_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_xilinx_exit_status_monitor
// Purpose  : Scoreboard bench for xilinx_exit_status_monitor. The stimulus
//            pushes the per-cycle output vectors it expects, and a monitor
//            pops one of them at every falling edge and compares.
//            HEARTBEAT_CYCLES=4, BLINK_CYCLES=2, GAP_CYCLES=6.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xilinx_exit_status_monitor;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        exit_valid_i = 1'b0;
  logic [31:0] exit_value_i = 32'd0;
  logic        exit_done_o, exit_pass_o, exit_fail_o, status_led_o;
  logic [31:0] exit_code_o;

  xilinx_exit_status_monitor #(
    .HEARTBEAT_CYCLES(4),
    .BLINK_CYCLES    (2),
    .GAP_CYCLES      (6)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .exit_valid_i (exit_valid_i),
    .exit_value_i (exit_value_i),
    .exit_done_o  (exit_done_o),
    .exit_pass_o  (exit_pass_o),
    .exit_fail_o  (exit_fail_o),
    .exit_code_o  (exit_code_o),
    .status_led_o (status_led_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        led;
    logic        done;
    logic        pass;
    logic        fail;
    logic [31:0] code;
    int          scen;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   vec_idx = 0;

  // Monitor: every falling edge with an expectation pending compares one vector.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      vec_idx++;
      if ({status_led_o, exit_done_o, exit_pass_o, exit_fail_o, exit_code_o} !==
          {mon_e.led, mon_e.done, mon_e.pass, mon_e.fail, mon_e.code}) begin
        errors++;
        $display("FAIL scen%0d vec%0d: got led=%b done=%b pass=%b fail=%b code=%h, want led=%b done=%b pass=%b fail=%b code=%h",
                 mon_e.scen, vec_idx, status_led_o, exit_done_o, exit_pass_o, exit_fail_o,
                 exit_code_o, mon_e.led, mon_e.done, mon_e.pass, mon_e.fail, mon_e.code);
      end
    end
  end

  // One expected vector per character of pat. The first character applies
  // to the next falling edge.
  task automatic push_pat(input int scen, input string pat, input logic done,
                          input logic pass, input logic fail, input logic [31:0] code);
    exp_t e;
    for (int i = 0; i < pat.len(); i++) begin
      e.led  = (pat[i] == 8'h31);
      e.done = done;
      e.pass = pass;
      e.fail = fail;
      e.code = code;
      e.scen = scen;
      exp_q.push_back(e);
    end
  endtask

  function automatic string rep(input string s, input int n);
    string r = "";
    for (int i = 0; i < n; i++) r = {r, s};
    return r;
  endfunction

  // Waits until the monitor has consumed every expectation, then returns at
  // rising edge + 2.
  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d vectors left unconsumed, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_i);
    #2;
  endtask

  // Asserts reset between clock edges. The next falling edge must already
  // show all-zero outputs.
  task automatic do_reset(input int scen);
    rst_ni = 1'b0;
    push_pat(scen, "0", 1'b0, 1'b0, 1'b0, 32'd0);
    drain();
  endtask

  task automatic pulse(input logic [31:0] v);
    exit_valid_i = 1'b1;
    exit_value_i = v;
    @(posedge clk_i);
    #2;
    exit_valid_i = 1'b0;
  endtask

  string p3, p4, p6;

  initial begin
`ifdef EXIT_BLINK_CODE_EN
    p3 = {rep("110011001100000000", 2), "11"};
    p4 = {rep("1100", 16), "000000", "1100"};
    p6 = rep("1100", 5);
`else
    p3 = rep("0011", 9);
    p4 = rep("0011", 5);
    p6 = rep("0011", 5);
`endif

    @(posedge clk_i);
    #2;
    // Reset held: outputs are at their reset values.
    push_pat(0, "00", 1'b0, 1'b0, 1'b0, 32'd0);
    drain();

    // 1: heartbeat, half-period 4, no flags.
    rst_ni = 1'b1;
    push_pat(1, "00001111000011110000", 1'b0, 1'b0, 1'b0, 32'd0);
    drain();

    // 2: pass capture with a one-cycle latency, then the LED is solid on.
    pulse(32'd0);
    push_pat(2, "11111111", 1'b1, 1'b1, 1'b0, 32'd0);
    drain();

    // 5: a later pulse with a new value, and a held level, are both ignored.
    repeat (4) begin
      @(posedge clk_i);
      #2;
    end
    pulse(32'd5);
    push_pat(5, "111111", 1'b1, 1'b1, 1'b0, 32'd0);
    drain();
    exit_valid_i = 1'b1;
    exit_value_i = 32'hFF;
    push_pat(5, "111111111111", 1'b1, 1'b1, 1'b0, 32'd0);
    repeat (10) begin
      @(posedge clk_i);
      #2;
    end
    exit_valid_i = 1'b0;
    drain();

    // 3: fail with code 3.
    do_reset(3);
    rst_ni = 1'b1;
    exit_value_i = 32'd0;
    push_pat(3, "0000", 1'b0, 1'b0, 1'b0, 32'd0);
    drain();
    pulse(32'h3);
    push_pat(3, p3, 1'b1, 1'b0, 1'b1, 32'h3);
    drain();

    // 4: fail with code 0x10 (zero low nibble).
    do_reset(4);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #2;
    pulse(32'h10);
    push_pat(4, p4, 1'b1, 1'b0, 1'b1, 32'h10);
    drain();

    // 6: valid already high at reset release is captured on the first edge.
    exit_valid_i = 1'b1;
    exit_value_i = 32'h7;
    do_reset(6);
    rst_ni = 1'b1;
    push_pat(6, "0", 1'b0, 1'b0, 1'b0, 32'd0);
    push_pat(6, p6, 1'b1, 1'b0, 1'b1, 32'h7);
    drain();
    exit_valid_i = 1'b0;
    // Reset in the middle of the fail pattern clears everything at once.
    do_reset(6);
    rst_ni = 1'b1;
    push_pat(6, "00001111", 1'b0, 1'b0, 1'b0, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
